// File: rtl/logic_ex_stage.sv
// logic_ex_stage: two-entry execute stage feeding a 32-bit bitwise logic bank and holding the result for writeback.
//   Inputs : clk, reset (sync, active-high), flush, in_valid/in_op/in_a/in_b/in_tag from issue,
//            and_res/or_res/xor_res/xnor_res/nor_res from the combinational logic bank, out_ready from writeback.
//   Outputs: in_ready to issue, lu_a/lu_b to the logic bank,
//            out_valid/out_result/out_tag/out_err (and out_zero) to writeback.
//   Optional: define LOGIC_EX_ZERO_FLAG_EN to add the out_zero result flag.
module logic_ex_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    input  logic [WIDTH-1:0] and_res,
    input  logic [WIDTH-1:0] or_res,
    input  logic [WIDTH-1:0] xor_res,
    input  logic [WIDTH-1:0] xnor_res,
    input  logic [WIDTH-1:0] nor_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
`ifdef LOGIC_EX_ZERO_FLAG_EN
   ,output logic             out_zero
`endif
);
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic [TAG_W-1:0] s1_tag_q, tag_q;
    logic             err_q, err_d, s1_adv, accept;
`ifdef LOGIC_EX_ZERO_FLAG_EN
    logic             zero_q;
    assign out_zero = zero_q;
`endif
    assign s1_adv     = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready   = !s1_valid_q || s1_adv;
    assign accept     = in_valid && in_ready;
    assign lu_a       = a_q;
    assign lu_b       = b_q;
    assign out_valid  = s2_valid_q;
    assign out_result = res_q;
    assign out_tag    = tag_q;
    assign out_err    = err_q;
    always_comb begin
        res_d = op_q == 3'd0 ? and_res  :
                op_q == 3'd1 ? or_res   :
                op_q == 3'd2 ? xor_res  :
                op_q == 3'd3 ? xnor_res :
                op_q == 3'd4 ? nor_res  :
                op_q == 3'd5 ? a_q      :
                op_q == 3'd6 ? {b_q[15:0], {(WIDTH-16){1'b0}}} : '0;
        err_d = op_q == 3'd7;
        // flush outranks everything; a new accept keeps S1 full even while it advances
        s1_valid_d = flush ? 1'b0 : accept ? 1'b1 : s1_adv ? 1'b0 : s1_valid_q;
        s2_valid_d = flush ? 1'b0 : s1_adv ? 1'b1 : out_ready ? 1'b0 : s2_valid_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            tag_q      <= '0;
            err_q      <= 1'b0;
`ifdef LOGIC_EX_ZERO_FLAG_EN
            zero_q     <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                op_q     <= in_op;
                a_q      <= in_a;
                b_q      <= in_b;
                s1_tag_q <= in_tag;
            end
            if (s1_adv) begin
                res_q <= res_d;
                tag_q <= s1_tag_q;
                err_q <= err_d;
`ifdef LOGIC_EX_ZERO_FLAG_EN
                zero_q <= res_d == '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_logic_ex_stage.sv
// tb_logic_ex_stage: random and directed checks of logic_ex_stage against an in-order queue model.
module tb_logic_ex_stage;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_err;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0, lu_a, lu_b, out_result;
    logic [31:0] and_res, or_res, xor_res, xnor_res, nor_res;
    logic [4:0]  in_tag = '0, out_tag;
`ifdef LOGIC_EX_ZERO_FLAG_EN
    logic        out_zero;
`endif
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [31:0] a, b, res;
        logic [4:0]  tag;
        logic        err;
        bit          s2;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    assign and_res  = lu_a & lu_b;
    assign or_res   = lu_a | lu_b;
    assign xor_res  = lu_a ^ lu_b;
    assign xnor_res = ~(lu_a ^ lu_b);
    assign nor_res  = ~(lu_a | lu_b);

    logic_ex_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .lu_a(lu_a), .lu_b(lu_b),
        .and_res(and_res), .or_res(or_res), .xor_res(xor_res),
        .xnor_res(xnor_res), .nor_res(nor_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_err(out_err)
`ifdef LOGIC_EX_ZERO_FLAG_EN
       ,.out_zero(out_zero)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] tag);
        ent_t e;
        e.a = a; e.b = b; e.tag = tag; e.s2 = 0; e.err = (op == 3'd7);
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: e.res = a ^ b;
            3'd3: e.res = ~(a ^ b);
            3'd4: e.res = ~(a | b);
            3'd5: e.res = a;
            3'd6: e.res = b << 16;
            default: e.res = 32'h0;
        endcase
        return e;
    endfunction

    task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic ordy, input logic fl);
        bit acc, drn, ov;
        @(negedge clk);
        in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy; flush = fl;
        #1;
        ov  = q.size() > 0 && q[0].s2;
        acc = v && (q.size() < 2 || ordy);
        drn = ov && ordy;
        chk("in_ready", in_ready, (q.size() < 2 || ordy));
        chk("out_valid", out_valid, ov);
        if (ov) begin
            chk("out_result", out_result, q[0].res);
            chk("out_tag", out_tag, q[0].tag);
            chk("out_err", out_err, q[0].err);
`ifdef LOGIC_EX_ZERO_FLAG_EN
            chk("out_zero", out_zero, q[0].res == 0);
`endif
        end
        if (q.size() > 0 && !q[q.size()-1].s2) begin
            chk("lu_a", lu_a, q[q.size()-1].a);
            chk("lu_b", lu_b, q[q.size()-1].b);
        end
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (q.size() > 0 && !q[0].s2) q[0].s2 = 1;
            if (acc) q.push_back(mk(op, a, b, tag));
        end
        if (q.size() > 2) chk("occupancy", q.size(), 2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; in_valid = 0; flush = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        q.delete();
        #1 reset = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", out_result, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_err", out_err, 0);
        chk("rst_lu_a", lu_a, 0);
        chk("rst_lu_b", lu_b, 0);
`ifdef LOGIC_EX_ZERO_FLAG_EN
        chk("rst_zero", out_zero, 0);
`endif
    endtask

    task automatic idle(input logic ordy);
        cycle(0, 3'd0, 32'h0, 32'h0, 5'd0, ordy, 0);
    endtask

    initial begin
        do_reset();
        idle(1);
        cycle(1, 3'd3, 32'hFFFF0000, 32'hFF00FF00, 5'd3, 1, 0);
        idle(1);
        #1;
        chk("xnor_valid", out_valid, 1);
        chk("xnor_result", out_result, 32'hFF0000FF);
        chk("xnor_tag", out_tag, 3);
        chk("xnor_err", out_err, 0);
        idle(1);
        cycle(1, 3'd0, 32'hF0F0F0F0, 32'h00001234, 5'd1, 1, 0);
        cycle(1, 3'd1, 32'hF0F0F0F0, 32'h00001234, 5'd2, 1, 0);
        cycle(1, 3'd4, 32'hF0F0F0F0, 32'h00001234, 5'd3, 1, 0);
        cycle(1, 3'd6, 32'hF0F0F0F0, 32'h00001234, 5'd4, 1, 0);
        idle(1);
        #1;
        chk("lui_result", out_result, 32'h12340000);
        chk("lui_tag", out_tag, 4);
        idle(1);
        idle(1);
        cycle(1, 3'd0, 32'h0000FFFF, 32'h00FF00FF, 5'd10, 0, 0);
        cycle(1, 3'd1, 32'h0000FFFF, 32'h00FF00FF, 5'd11, 0, 0);
        #1;
        chk("stall_in_ready", in_ready, 0);
        repeat (3) cycle(1, 3'd2, 32'h0000FFFF, 32'h00FF00FF, 5'd12, 0, 0);
        #1;
        chk("stall_hold_tag", out_tag, 10);
        chk("stall_hold_result", out_result, 32'h000000FF);
        cycle(1, 3'd2, 32'h0000FFFF, 32'h00FF00FF, 5'd12, 1, 0);
        repeat (3) idle(1);
        cycle(1, 3'd7, 32'h12345678, 32'h9ABCDEF0, 5'd7, 1, 0);
        idle(0);
        #1;
        chk("ill_err", out_err, 1);
        chk("ill_result", out_result, 0);
`ifdef LOGIC_EX_ZERO_FLAG_EN
        chk("ill_zero", out_zero, 1);
`endif
        idle(1);
        cycle(1, 3'd0, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd20, 0, 0);
        cycle(1, 3'd1, 32'hAAAAAAAA, 32'h55555555, 5'd21, 0, 0);
        cycle(1, 3'd2, 32'hAAAAAAAA, 32'h55555555, 5'd22, 1, 1);
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        idle(1);
        #1;
        chk("flush_no_accept", out_valid, 0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  5'($urandom_range(0, 31)), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end
        repeat (3) idle(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
